axi_read_responder: RTL and testbench

DRAM-side AXI read-channel responder for the prefetcher: accepts AR requests, queues them in order, and returns R data bursts that the prefetcher data queue consumes as its read-response traffic. It lets the prefetcher be exercised and integrated without a real memory controller. Data is not stored; each beat carries a deterministic, address-derived pattern so that the prefetcher's captured block contents can be checked.

---
 rtl/axi_read_responder_if.sv | 29 ++
 rtl/axi_read_responder.sv | 169 ++++++++++++++++
 tb/tb_axi_read_responder.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/axi_read_responder_if.sv
// AR/R channel bundle between the prefetcher (master) and the read responder (slave).
interface axi_read_responder_if #(
  parameter int unsigned ADDR_BITS = 64,
  parameter int unsigned DATA_BITS = 512,
  parameter int unsigned ID_BITS   = 4
);
  logic                 arValid;
  logic                 arReady;
  logic [ADDR_BITS-1:0] arAddr;
  logic [ID_BITS-1:0]   arId;
  logic [7:0]           arLen;

  logic                 rValid;
  logic                 rReady;
  logic [DATA_BITS-1:0] rData;
  logic [ID_BITS-1:0]   rId;
  logic                 rLast;
  logic [1:0]           rResp;

  modport master (
    output arValid, arAddr, arId, arLen, rReady,
    input  arReady, rValid, rData, rId, rLast, rResp
  );

  modport slave (
    input  arValid, arAddr, arId, arLen, rReady,
    output arReady, rValid, rData, rId, rLast, rResp
  );
endinterface

// File: rtl/axi_read_responder.sv
// In-order AXI read responder: queues AR requests and returns bursts whose beats
// carry an address-derived pattern (lane i = beat address + 8*i).
module axi_read_responder #(
  parameter int unsigned ADDR_BITS            = 64,
  parameter int unsigned LOG_BLOCK_DATA_BYTES = 6,
  parameter int unsigned ID_BITS              = 4,
  parameter int unsigned LOG_AR_DEPTH         = 2,
  parameter int unsigned RESP_LATENCY         = 4
) (
  input  logic                  clk,
  input  logic                  resetN,
  axi_read_responder_if.slave   bus,
  output logic [LOG_AR_DEPTH:0] outstandingCnt
);
  localparam int unsigned DATA_BITS   = 8 * (1 << LOG_BLOCK_DATA_BYTES);
  localparam int unsigned LANES       = DATA_BITS / 64;
  localparam int unsigned DEPTH       = 1 << LOG_AR_DEPTH;
  localparam int unsigned BLOCK_BYTES = 1 << LOG_BLOCK_DATA_BYTES;
  localparam int unsigned CNT_W       = LOG_AR_DEPTH + 1;
  localparam int unsigned WAIT_W      = (RESP_LATENCY > 0) ? $clog2(RESP_LATENCY + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_t;

  typedef struct packed {
    logic [ADDR_BITS-1:0] addr;
    logic [ID_BITS-1:0]   id;
    logic [7:0]           len;
  } ar_req_t;

  ar_req_t                 mem_q [DEPTH];
  ar_req_t                 head;
  ar_req_t                 ar_in;
  logic [LOG_AR_DEPTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    push, pop;

  state_t                  state_q, state_d;
  logic [WAIT_W-1:0]       wait_q, wait_d;
  logic [7:0]              len_q, len_d, beat_cnt_q, beat_cnt_d;
  logic [ADDR_BITS-1:0]    beat_addr_q, beat_addr_d;

  logic                    ar_ready_q, ar_ready_d;
  logic                    r_valid_q, r_valid_d;
  logic                    r_last_q, r_last_d;
  logic [1:0]              resp_q, resp_d;
  logic [ID_BITS-1:0]      id_q, id_d;
  logic [DATA_BITS-1:0]    data_q, data_d;
  logic [CNT_W-1:0]        outstanding_q, outstanding_d;

  function automatic logic [DATA_BITS-1:0] beat_pattern(input logic [ADDR_BITS-1:0] addr);
    logic [DATA_BITS-1:0] d;
    d = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      d[64*i +: 64] = 64'(addr) + 64'(8 * i);
    end
    return d;
  endfunction

  assign ar_in = '{addr: bus.arAddr, id: bus.arId, len: bus.arLen};
  assign head  = mem_q[rd_ptr_q];
  assign push  = bus.arValid && ar_ready_q;

  // Request storage carries no reset; only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= ar_in;
  end

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    id_d        = id_q;
    len_d       = len_q;
    beat_cnt_d  = beat_cnt_q;
    beat_addr_d = beat_addr_q;
    resp_d      = resp_q;
    data_d      = data_q;
    pop         = 1'b0;

    case (state_q)
      S_IDLE:  pop = (count_q != '0);
      S_WAIT: begin
        if (wait_q == WAIT_W'(1)) state_d = S_BURST;
        else                      wait_d  = wait_q - WAIT_W'(1);
      end
      S_BURST: begin
        if (bus.rReady) begin
          if (beat_cnt_q == len_q) begin
            if (count_q != '0) pop     = 1'b1;
            else               state_d = S_IDLE;
          end else begin
            beat_cnt_d  = beat_cnt_q + 8'd1;
            beat_addr_d = beat_addr_q + ADDR_BITS'(BLOCK_BYTES);
            data_d      = beat_pattern(beat_addr_d);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Load the queue head into the active burst; misaligned requests answer SLVERR.
    if (pop) begin
      id_d        = head.id;
      len_d       = head.len;
      beat_cnt_d  = '0;
      beat_addr_d = {head.addr[ADDR_BITS-1:LOG_BLOCK_DATA_BYTES], {LOG_BLOCK_DATA_BYTES{1'b0}}};
      resp_d      = (head.addr[LOG_BLOCK_DATA_BYTES-1:0] != '0) ? 2'b10 : 2'b00;
      data_d      = beat_pattern(beat_addr_d);
      if (RESP_LATENCY == 0) begin
        state_d = S_BURST;
      end else begin
        state_d = S_WAIT;
        wait_d  = WAIT_W'(RESP_LATENCY);
      end
    end

    wr_ptr_d      = wr_ptr_q + LOG_AR_DEPTH'(push);
    rd_ptr_d      = rd_ptr_q + LOG_AR_DEPTH'(pop);
    count_d       = count_q + CNT_W'(push) - CNT_W'(pop);

    r_valid_d     = (state_d == S_BURST);
    r_last_d      = r_valid_d && (beat_cnt_d == len_d);
    ar_ready_d    = (count_d != CNT_W'(DEPTH));
    outstanding_d = count_d + CNT_W'(state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= S_IDLE;
      wait_q        <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      len_q         <= '0;
      beat_cnt_q    <= '0;
      beat_addr_q   <= '0;
      id_q          <= '0;
      resp_q        <= '0;
      data_q        <= '0;
      ar_ready_q    <= 1'b1;
      r_valid_q     <= 1'b0;
      r_last_q      <= 1'b0;
      outstanding_q <= '0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      len_q         <= len_d;
      beat_cnt_q    <= beat_cnt_d;
      beat_addr_q   <= beat_addr_d;
      id_q          <= id_d;
      resp_q        <= resp_d;
      data_q        <= data_d;
      ar_ready_q    <= ar_ready_d;
      r_valid_q     <= r_valid_d;
      r_last_q      <= r_last_d;
      outstanding_q <= outstanding_d;
    end
  end

  assign bus.arReady    = ar_ready_q;
  assign bus.rValid     = r_valid_q;
  assign bus.rData      = data_q;
  assign bus.rId        = id_q;
  assign bus.rLast      = r_last_q;
  assign bus.rResp      = resp_q;
  assign outstandingCnt = outstanding_q;
endmodule

// File: tb/tb_axi_read_responder.sv
// Directed self-checking bench for axi_read_responder at default parameters.
module tb_axi_read_responder;
  logic       clk;
  logic       resetN;
  logic [2:0] outstandingCnt;
  int         checks;
  int         errors;

  axi_read_responder_if #(.ADDR_BITS(64), .DATA_BITS(512), .ID_BITS(4)) bus ();

  axi_read_responder #(
    .ADDR_BITS(64), .LOG_BLOCK_DATA_BYTES(6), .ID_BITS(4),
    .LOG_AR_DEPTH(2), .RESP_LATENCY(4)
  ) dut (
    .clk(clk), .resetN(resetN), .bus(bus), .outstandingCnt(outstandingCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_ar(input logic [63:0] addr, input logic [3:0] id, input logic [7:0] len);
    bus.arValid = 1'b1;
    bus.arAddr  = addr;
    bus.arId    = id;
    bus.arLen   = len;
    tick();
    bus.arValid = 1'b0;
  endtask

  task automatic wait_rvalid(input string tag, output int lat);
    lat = 0;
    while (bus.rValid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    checks++;
    if (bus.rValid !== 1'b1) begin errors++; $display("FAIL %s_timeout: rValid got %0b want 1", tag, bus.rValid); end
  endtask

  task automatic test_reset();
    checks++; if (bus.arReady !== 1'b1) begin errors++; $display("FAIL rst_arready: got %0b want 1", bus.arReady); end
    checks++; if (bus.rValid !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %0b want 0", bus.rValid); end
    checks++; if (bus.rLast !== 1'b0) begin errors++; $display("FAIL rst_rlast: got %0b want 0", bus.rLast); end
    checks++; if (bus.rResp !== 2'b00) begin errors++; $display("FAIL rst_rresp: got %b want 00", bus.rResp); end
    checks++; if (bus.rId !== 4'd0) begin errors++; $display("FAIL rst_rid: got %0d want 0", bus.rId); end
    checks++; if (bus.rData !== 512'd0) begin errors++; $display("FAIL rst_rdata: got %h want 0", bus.rData[63:0]); end
    checks++; if (outstandingCnt !== 3'd0) begin errors++; $display("FAIL rst_outstanding: got %0d want 0", outstandingCnt); end
  endtask

  task automatic test_single_beat();
    int lat;
    bus.rReady = 1'b1;
    send_ar(64'h1000, 4'd3, 8'd0);
    checks++; if (outstandingCnt !== 3'd1) begin errors++; $display("FAIL single_outst_1: got %0d want 1", outstandingCnt); end
    wait_rvalid("single", lat);
    checks++; if (lat != 5) begin errors++; $display("FAIL single_latency: got %0d want 5", lat); end
    checks++; if (bus.rData[63:0] !== 64'h1000) begin errors++; $display("FAIL single_lane0: got %h want 1000", bus.rData[63:0]); end
    checks++; if (bus.rData[511:448] !== 64'h1038) begin errors++; $display("FAIL single_lane7: got %h want 1038", bus.rData[511:448]); end
    checks++; if (bus.rLast !== 1'b1) begin errors++; $display("FAIL single_rlast: got %0b want 1", bus.rLast); end
    checks++; if (bus.rId !== 4'd3) begin errors++; $display("FAIL single_rid: got %0d want 3", bus.rId); end
    checks++; if (bus.rResp !== 2'b00) begin errors++; $display("FAIL single_rresp: got %b want 00", bus.rResp); end
    checks++; if (outstandingCnt !== 3'd1) begin errors++; $display("FAIL single_outst_active: got %0d want 1", outstandingCnt); end
    tick();
    checks++; if (bus.rValid !== 1'b0) begin errors++; $display("FAIL single_rvalid_end: got %0b want 0", bus.rValid); end
    checks++; if (outstandingCnt !== 3'd0) begin errors++; $display("FAIL single_outst_0: got %0d want 0", outstandingCnt); end
  endtask

  task automatic test_burst();
    int lat;
    logic [63:0] exp;
    bus.rReady = 1'b1;
    send_ar(64'h2000, 4'd5, 8'd3);
    wait_rvalid("burst", lat);
    for (int b = 0; b < 4; b++) begin
      exp = 64'h2000 + 64'(64 * b);
      checks++; if (bus.rValid !== 1'b1) begin errors++; $display("FAIL burst_rvalid b%0d: got %0b want 1", b, bus.rValid); end
      checks++; if (bus.rData[63:0] !== exp) begin errors++; $display("FAIL burst_lane0 b%0d: got %h want %h", b, bus.rData[63:0], exp); end
      checks++; if (bus.rLast !== (b == 3)) begin errors++; $display("FAIL burst_rlast b%0d: got %0b want %0b", b, bus.rLast, b == 3); end
      checks++; if (bus.rId !== 4'd5) begin errors++; $display("FAIL burst_rid b%0d: got %0d want 5", b, bus.rId); end
      tick();
    end
    checks++; if (bus.rValid !== 1'b0) begin errors++; $display("FAIL burst_rvalid_end: got %0b want 0", bus.rValid); end
  endtask

  task automatic test_backpressure();
    int lat;
    bus.rReady = 1'b1;
    send_ar(64'h2000, 4'd6, 8'd3);
    wait_rvalid("bp", lat);
    checks++; if (bus.rData[63:0] !== 64'h2000) begin errors++; $display("FAIL bp_beat0: got %h want 2000", bus.rData[63:0]); end
    tick();
    checks++; if (bus.rData[63:0] !== 64'h2040) begin errors++; $display("FAIL bp_beat1: got %h want 2040", bus.rData[63:0]); end
    tick();
    bus.rReady = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) bus.rReady = 1'b1;
      checks++; if (bus.rValid !== 1'b1) begin errors++; $display("FAIL bp_hold_rvalid k%0d: got %0b want 1", k, bus.rValid); end
      checks++; if (bus.rData[63:0] !== 64'h2080) begin errors++; $display("FAIL bp_hold_lane0 k%0d: got %h want 2080", k, bus.rData[63:0]); end
      checks++; if (bus.rLast !== 1'b0) begin errors++; $display("FAIL bp_hold_rlast k%0d: got %0b want 0", k, bus.rLast); end
      tick();
    end
    checks++; if (bus.rData[63:0] !== 64'h20C0) begin errors++; $display("FAIL bp_beat3: got %h want 20c0", bus.rData[63:0]); end
    checks++; if (bus.rLast !== 1'b1) begin errors++; $display("FAIL bp_beat3_rlast: got %0b want 1", bus.rLast); end
    tick();
    checks++; if (bus.rValid !== 1'b0) begin errors++; $display("FAIL bp_rvalid_end: got %0b want 0", bus.rValid); end
  endtask

  task automatic test_queue_full();
    int   n;
    logic acc, rise_chk;
    logic [63:0] exp;
    bus.rReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.arValid = 1'b1;
      bus.arAddr  = 64'h4000 + 64'(i * 256);
      bus.arId    = 4'(i);
      bus.arLen   = 8'd0;
      checks++; if (bus.arReady !== 1'b1) begin errors++; $display("FAIL qf_accept id%0d: arReady got %0b want 1", i, bus.arReady); end
      tick();
    end
    bus.arAddr = 64'h4500;
    bus.arId   = 4'd5;
    for (int k = 0; k < 3; k++) begin
      checks++; if (bus.arReady !== 1'b0) begin errors++; $display("FAIL qf_full k%0d: arReady got %0b want 0", k, bus.arReady); end
      checks++; if (outstandingCnt !== 3'd5) begin errors++; $display("FAIL qf_outst k%0d: got %0d want 5", k, outstandingCnt); end
      tick();
    end
    bus.rReady = 1'b1;
    n = 0;
    rise_chk = 1'b0;
    for (int cyc = 0; cyc < 200 && n < 6; cyc++) begin
      acc = bus.arValid && bus.arReady;
      if (bus.rValid === 1'b1) begin
        exp = 64'h4000 + 64'(n * 256);
        if (n == 0) begin
          checks++; if (bus.arReady !== 1'b0) begin errors++; $display("FAIL qf_ready_early: got %0b want 0", bus.arReady); end
          rise_chk = 1'b1;
        end
        checks++; if (bus.rId !== 4'(n)) begin errors++; $display("FAIL qf_order n%0d: rId got %0d want %0d", n, bus.rId, n); end
        checks++; if (bus.rData[63:0] !== exp) begin errors++; $display("FAIL qf_lane0 n%0d: got %h want %h", n, bus.rData[63:0], exp); end
        n++;
      end
      tick();
      if (acc) bus.arValid = 1'b0;
      if (rise_chk) begin
        checks++; if (bus.arReady !== 1'b1) begin errors++; $display("FAIL qf_ready_rise: got %0b want 1", bus.arReady); end
        rise_chk = 1'b0;
      end
    end
    bus.arValid = 1'b0;
    checks++; if (n != 6) begin errors++; $display("FAIL qf_count: bursts got %0d want 6", n); end
    tick();
    checks++; if (outstandingCnt !== 3'd0) begin errors++; $display("FAIL qf_drain: outstanding got %0d want 0", outstandingCnt); end
  endtask

  task automatic test_unaligned_wrap();
    int lat;
    bus.rReady = 1'b1;
    send_ar(64'h1010, 4'd1, 8'd1);
    wait_rvalid("unal", lat);
    checks++; if (bus.rData[63:0] !== 64'h1000) begin errors++; $display("FAIL unal_beat0: got %h want 1000", bus.rData[63:0]); end
    checks++; if (bus.rResp !== 2'b10) begin errors++; $display("FAIL unal_resp0: got %b want 10", bus.rResp); end
    tick();
    checks++; if (bus.rData[63:0] !== 64'h1040) begin errors++; $display("FAIL unal_beat1: got %h want 1040", bus.rData[63:0]); end
    checks++; if (bus.rResp !== 2'b10) begin errors++; $display("FAIL unal_resp1: got %b want 10", bus.rResp); end
    checks++; if (bus.rLast !== 1'b1) begin errors++; $display("FAIL unal_rlast: got %0b want 1", bus.rLast); end
    tick();
    send_ar(64'hFFFF_FFFF_FFFF_FFC0, 4'd2, 8'd1);
    wait_rvalid("wrap", lat);
    checks++; if (bus.rData[63:0] !== 64'hFFFF_FFFF_FFFF_FFC0) begin errors++; $display("FAIL wrap_beat0: got %h want ffffffffffffffc0", bus.rData[63:0]); end
    checks++; if (bus.rData[127:64] !== 64'hFFFF_FFFF_FFFF_FFC8) begin errors++; $display("FAIL wrap_beat0_lane1: got %h want ffffffffffffffc8", bus.rData[127:64]); end
    checks++; if (bus.rResp !== 2'b00) begin errors++; $display("FAIL wrap_resp: got %b want 00", bus.rResp); end
    tick();
    checks++; if (bus.rData[63:0] !== 64'h0) begin errors++; $display("FAIL wrap_beat1_lane0: got %h want 0", bus.rData[63:0]); end
    checks++; if (bus.rData[511:448] !== 64'h38) begin errors++; $display("FAIL wrap_beat1_lane7: got %h want 38", bus.rData[511:448]); end
    tick();
  endtask

  task automatic test_reset_mid_burst();
    int lat;
    bus.rReady = 1'b1;
    send_ar(64'h5000, 4'd7, 8'd7);
    wait_rvalid("rstmid", lat);
    tick();
    tick();
    checks++; if (bus.rData[63:0] !== 64'h5080) begin errors++; $display("FAIL rstmid_beat2: got %h want 5080", bus.rData[63:0]); end
    #1 resetN = 1'b0;
    #1;
    checks++; if (bus.rValid !== 1'b0) begin errors++; $display("FAIL rstmid_rvalid: got %0b want 0", bus.rValid); end
    checks++; if (outstandingCnt !== 3'd0) begin errors++; $display("FAIL rstmid_outst: got %0d want 0", outstandingCnt); end
    checks++; if (bus.arReady !== 1'b1) begin errors++; $display("FAIL rstmid_arready: got %0b want 1", bus.arReady); end
    tick();
    resetN = 1'b1;
    tick();
    send_ar(64'h3000, 4'd9, 8'd1);
    wait_rvalid("post", lat);
    checks++; if (lat != 5) begin errors++; $display("FAIL post_latency: got %0d want 5", lat); end
    checks++; if (bus.rId !== 4'd9) begin errors++; $display("FAIL post_rid: got %0d want 9", bus.rId); end
    checks++; if (bus.rData[63:0] !== 64'h3000) begin errors++; $display("FAIL post_beat0: got %h want 3000", bus.rData[63:0]); end
    tick();
    checks++; if (bus.rData[63:0] !== 64'h3040) begin errors++; $display("FAIL post_beat1: got %h want 3040", bus.rData[63:0]); end
    checks++; if (bus.rLast !== 1'b1) begin errors++; $display("FAIL post_rlast: got %0b want 1", bus.rLast); end
    tick();
    checks++; if (bus.rValid !== 1'b0) begin errors++; $display("FAIL post_rvalid_end: got %0b want 0", bus.rValid); end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    resetN      = 1'b0;
    bus.arValid = 1'b0;
    bus.arAddr  = '0;
    bus.arId    = '0;
    bus.arLen   = '0;
    bus.rReady  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    resetN = 1'b1;
    tick();
    test_single_beat();
    test_burst();
    test_backpressure();
    test_queue_full();
    test_unaligned_wrap();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
